// File: rtl/async_mem_initiator.sv
// Requester side of the phased async_mem port.
// Core-side requests are buffered in a small FIFO. Each request is issued to
// async_mem in an access window that opens when the phase counter matches
// ISSUE_PHASE. The window commits (write strobe / rdata capture) on the edge
// that ends the COMPLETE_PHASE cycle. Only one access is outstanding at a time,
// and responses return strictly in request order.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both 1. A source holds valid and its payload stable
// until that transfer. req_ready depends only on FIFO occupancy and rst, never
// on req_valid. resp_rdata is held while resp_valid && !resp_ready.
module async_mem_initiator #(
  parameter int          FIFO_DEPTH     = 2,
  parameter logic [1:0]  ISSUE_PHASE    = 2'd0,
  parameter logic [1:0]  COMPLETE_PHASE = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  counter,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [7:0]  raddr,
  input  logic [31:0] rdata,
  output logic [7:0]  waddr,
  output logic        write,
  output logic [31:0] wdata
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + 8 + 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;

  // Request FIFO: entry layout is {write, addr, wdata}.
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // Request currently being issued to memory.
  logic        cur_write;
  logic [7:0]  cur_addr;
  logic [31:0] cur_wdata;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  // A full FIFO refuses a push even if the head pops in the same cycle.
  assign req_ready = !full && !rst;
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && !empty;
  assign head      = fifo_mem[rd_ptr];

  // FIFO storage: payload only, no reset needed since count guards it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {req_write, req_addr, req_wdata};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of 2).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Access sequencer: pop, wait for the issue phase, run the window, hand back the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_write  <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            {cur_write, cur_addr, cur_wdata} <= head;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          if (counter == ISSUE_PHASE) state <= ACCESS;
        end
        ACCESS: begin
          if (counter == COMPLETE_PHASE) begin
            resp_rdata <= cur_write ? 32'd0 : rdata;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side address/data simply reflect the current request register.
  assign raddr = cur_addr;
  assign waddr = cur_addr;
  assign wdata = cur_wdata;
  // One-cycle strobe in the commit cycle; dropped immediately by reset.
  assign write = !rst && cur_write && (state == ACCESS) && (counter == COMPLETE_PHASE);

endmodule

// File: tb/tb_async_mem_initiator.sv
// Bench for async_mem_initiator: free-running phase counter, behavioural
// async_mem model, directed request vectors and an in-order response scoreboard.
module tb_async_mem_initiator;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  counter = 2'd0;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [7:0]  raddr;
  logic [31:0] rdata;
  logic [7:0]  waddr;
  logic        write;
  logic [31:0] wdata;

  always #5 clk = ~clk;

  // Phase counter as produced by internal_clk_gen: 0,1,2,3,0,...
  always @(posedge clk) counter <= counter + 2'd1;

  async_mem_initiator dut (
    .clk(clk), .rst(rst), .counter(counter),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .raddr(raddr), .rdata(rdata), .waddr(waddr), .write(write), .wdata(wdata)
  );

  // ---------------- async_mem model ----------------
  logic [31:0] mem [256];
  logic        init_done = 1'b0;

  always_comb rdata = mem[raddr];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[0] <= 32'h1111_0000;
      mem[1] <= 32'h2222_0001;
      mem[2] <= 32'h3333_0002;
      mem[3] <= 32'h4444_0003;
      init_done <= 1'b1;
    end else if (write) begin
      mem[waddr] <= wdata;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          write_pulses = 0;
  logic [7:0]  last_waddr;
  logic [31:0] last_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Response monitor: one pop per handshaked response.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL resp_unexpected: got %h expected no response", resp_rdata);
      end else begin
        check("resp_rdata", resp_rdata, exp_q.pop_front());
      end
    end
  end

  // Write-strobe monitor: every strobe must land in the commit phase.
  always @(negedge clk) begin
    if (write) begin
      write_pulses++;
      last_waddr = waddr;
      last_wdata = wdata;
      check("write_phase", {30'd0, counter}, 32'd3);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_req(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [31:0] exp);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 200) begin
      step(1);
      n++;
    end
    if (n >= 200) begin
      timeout_fail("req_accept");
    end else begin
      exp_q.push_back(exp);
      step(1);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || resp_valid) && n < 300) begin
      step(1);
      n++;
    end
    if (n >= 300) timeout_fail(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  k;
    int  n;
    int  pulses0;
    logic ok;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 8'h00;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;

    // Test 1: reset state
    step(3);
    check("rst_write",      {31'd0, write},      32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_raddr",      {24'd0, raddr},      32'd0);
    check("rst_waddr",      {24'd0, waddr},      32'd0);
    check("rst_req_ready",  {31'd0, req_ready},  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    step(1);

    // Test 2: write then read at 8'h1C
    pulses0 = write_pulses;
    send_req(1'b1, 8'h1C, 32'hDEAD_BEEF, 32'd0);
    send_req(1'b0, 8'h1C, 32'd0,         32'hDEAD_BEEF);
    drain("t2_drain");
    check("t2_write_pulses", write_pulses - pulses0, 32'd1);
    check("t2_waddr",        {24'd0, last_waddr},    32'h0000_001C);
    check("t2_wdata",        last_wdata,             32'hDEAD_BEEF);

    // Test 3: phase alignment. Accepted at the edge ending a counter=1 cycle;
    // following cycles: 2 IDLE(pop), 3 ALIGN, 0 ALIGN, 1,2,3 ACCESS, 0 resp_valid.
    n = 0;
    while (counter != 2'd1 && n < 8) begin
      step(1);
      n++;
    end
    send_req(1'b0, 8'h1C, 32'd0, 32'hDEAD_BEEF);
    k  = 1;
    ok = 1'b1;
    while (!resp_valid && k < 20) begin
      if (k >= 2 && raddr !== 8'h1C) ok = 1'b0;
      step(1);
      k++;
    end
    check("t3_latency",      k,                    32'd7);
    check("t3_phase",        {30'd0, counter},     32'd0);
    check("t3_raddr_stable", {31'd0, ok},          32'd1);
    drain("t3_drain");

    // Test 4: backpressure, 1 in flight + 2 queued
    resp_ready = 1'b0;
    send_req(1'b0, 8'h1C, 32'd0,         32'hDEAD_BEEF);
    send_req(1'b1, 8'h40, 32'h1111_1111, 32'd0);
    send_req(1'b0, 8'h40, 32'd0,         32'h1111_1111);
    check("t4_full_req_ready", {31'd0, req_ready}, 32'd0);
    n = 0;
    while (!resp_valid && n < 50) begin
      step(1);
      n++;
    end
    if (n >= 50) timeout_fail("t4_resp_valid");
    check("t4_hold_rdata0", resp_rdata, 32'hDEAD_BEEF);
    step(3);
    check("t4_hold_valid",  {31'd0, resp_valid}, 32'd1);
    check("t4_hold_rdata1", resp_rdata,          32'hDEAD_BEEF);
    check("t4_still_full",  {31'd0, req_ready},  32'd0);
    resp_ready = 1'b1;
    drain("t4_drain");

    // Test 5: reset in the middle of a write commit
    send_req(1'b1, 8'h50, 32'hAAAA_5555, 32'd0);
    drain("t5_pre_drain");
    send_req(1'b1, 8'h50, 32'h1234_5678, 32'd0);
    send_req(1'b1, 8'h51, 32'hCAFE_F00D, 32'd0);
    n = 0;
    while (!write && n < 50) begin
      step(1);
      n++;
    end
    if (n >= 50) timeout_fail("t5_wait_write");
    rst = 1'b1;
    #1;
    check("t5_write_dropped", {31'd0, write}, 32'd0);
    step(1);
    exp_q.delete();
    step(2);
    rst = 1'b0;
    #1;
    check("t5_req_ready", {31'd0, req_ready}, 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) ok = 1'b0;
      step(1);
    end
    check("t5_no_resp", {31'd0, ok}, 32'd1);
    send_req(1'b0, 8'h50, 32'd0, 32'hAAAA_5555);
    send_req(1'b0, 8'h51, 32'd0, 32'd0);
    drain("t5_drain");

    // Test 6: back-to-back reads of preloaded words
    send_req(1'b0, 8'h00, 32'd0, 32'h1111_0000);
    send_req(1'b0, 8'h01, 32'd0, 32'h2222_0001);
    send_req(1'b0, 8'h02, 32'd0, 32'h3333_0002);
    send_req(1'b0, 8'h03, 32'd0, 32'h4444_0003);
    drain("t6_drain");

    step(2);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
